// File: rtl/ps2_cmd_queue.sv
// ps2_cmd_queue: raw PS/2 keyboard line -> game command FIFO behind a ready/read_fin handshake.
// Optional macro PS2_CMD_REPEAT_EN lets typematic repeats through (no held-key bitmap).
`timescale 1ns/1ps
module ps2_cmd_queue #(
   parameter int CMD_WIDTH      = 3,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 ps2_clock,
   input  logic                 ps2_data,
   input  logic                 read_fin,
   output logic                 ready,
   output logic [CMD_WIDTH-1:0] data,
   output logic                 overflow
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   // Synchronisers reset high so leaving reset never fakes a falling edge.
   logic ps2_clk_meta_reg, ps2_clk_sync_reg, ps2_clk_prev_reg;
   logic ps2_dat_meta_reg, ps2_dat_sync_reg;
   logic fall;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ps2_clk_meta_reg <= 1'b1;
         ps2_clk_sync_reg <= 1'b1;
         ps2_clk_prev_reg <= 1'b1;
         ps2_dat_meta_reg <= 1'b1;
         ps2_dat_sync_reg <= 1'b1;
      end else begin
         ps2_clk_meta_reg <= ps2_clock;
         ps2_clk_sync_reg <= ps2_clk_meta_reg;
         ps2_clk_prev_reg <= ps2_clk_sync_reg;
         ps2_dat_meta_reg <= ps2_data;
         ps2_dat_sync_reg <= ps2_dat_meta_reg;
      end
   end

   assign fall = ps2_clk_prev_reg & ~ps2_clk_sync_reg;

   typedef enum logic {ST_IDLE, ST_SHIFT} frame_state_t;
   frame_state_t     state_reg, state_next;
   logic [3:0]       bit_cnt_reg, bit_cnt_next;
   logic [8:0]       shift_reg, shift_next;
   logic [TMO_W-1:0] tmo_reg, tmo_next;
   logic             byte_valid_reg, byte_valid_next;
   logic             abort_reg, abort_next;
   logic [7:0]       byte_reg, byte_next;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         tmo_reg        <= '0;
         byte_valid_reg <= 1'b0;
         abort_reg      <= 1'b0;
         byte_reg       <= '0;
      end else begin
         state_reg      <= state_next;
         bit_cnt_reg    <= bit_cnt_next;
         shift_reg      <= shift_next;
         tmo_reg        <= tmo_next;
         byte_valid_reg <= byte_valid_next;
         abort_reg      <= abort_next;
         byte_reg       <= byte_next;
      end
   end

   // Data and parity shift in from the top; after 9 shifts [7:0] is the byte, [8] the parity.
   always_comb begin
      state_next      = state_reg;
      bit_cnt_next    = bit_cnt_reg;
      shift_next      = shift_reg;
      tmo_next        = tmo_reg;
      byte_valid_next = 1'b0;
      abort_next      = 1'b0;
      byte_next       = byte_reg;
      case (state_reg)
         ST_IDLE: begin
            tmo_next = '0;
            if (fall && !ps2_dat_sync_reg) begin
               state_next   = ST_SHIFT;
               bit_cnt_next = '0;
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               tmo_next = '0;
               if (bit_cnt_reg == 4'd9) begin
                  state_next = ST_IDLE;
                  if ((^shift_reg) && ps2_dat_sync_reg) begin
                     byte_valid_next = 1'b1;
                     byte_next       = shift_reg[7:0];
                  end else begin
                     abort_next = 1'b1;
                  end
               end else begin
                  shift_next   = {ps2_dat_sync_reg, shift_reg[8:1]};
                  bit_cnt_next = bit_cnt_reg + 4'd1;
               end
            end else if (tmo_reg == TMO_LAST) begin
               state_next = ST_IDLE;
               tmo_next   = '0;
               abort_next = 1'b1;
            end else begin
               tmo_next = tmo_reg + TMO_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   logic       ext_reg, ext_next, brk_reg, brk_next;
   logic       resolve;
   logic [2:0] map_cmd;
   logic       push;
   logic [CMD_WIDTH-1:0] push_cmd;

   always_comb begin
      map_cmd = 3'd0;
      if (ext_reg) begin
         case (byte_reg)
            8'h75:   map_cmd = 3'd1;
            8'h72:   map_cmd = 3'd2;
            8'h6B:   map_cmd = 3'd3;
            8'h74:   map_cmd = 3'd4;
            default: map_cmd = 3'd0;
         endcase
      end else begin
         case (byte_reg)
            8'h1A:   map_cmd = 3'd5;
            8'h22:   map_cmd = 3'd6;
            8'h29:   map_cmd = 3'd7;
            default: map_cmd = 3'd0;
         endcase
      end
   end

   always_comb begin
      ext_next = ext_reg;
      brk_next = brk_reg;
      resolve  = 1'b0;
      if (abort_reg) begin
         ext_next = 1'b0;
         brk_next = 1'b0;
      end else if (byte_valid_reg) begin
         if (byte_reg == 8'hE0) begin
            ext_next = 1'b1;
         end else if (byte_reg == 8'hF0) begin
            brk_next = 1'b1;
         end else begin
            resolve  = 1'b1;
            ext_next = 1'b0;
            brk_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ext_reg <= 1'b0;
         brk_reg <= 1'b0;
      end else begin
         ext_reg <= ext_next;
         brk_reg <= brk_next;
      end
   end

   assign push_cmd = CMD_WIDTH'(map_cmd);

`ifdef PS2_CMD_REPEAT_EN
   assign push = resolve && (map_cmd != 3'd0) && !brk_reg;
`else
   // Bit (cmd-1) is set while the key for cmd is held down.
   logic [6:0] held_reg, held_next;
   logic [2:0] held_idx;

   assign held_idx = map_cmd - 3'd1;

   always_comb begin
      held_next = held_reg;
      push      = 1'b0;
      if (resolve && map_cmd != 3'd0) begin
         if (brk_reg) begin
            held_next[held_idx] = 1'b0;
         end else if (!held_reg[held_idx]) begin
            held_next[held_idx] = 1'b1;
            push                = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) held_reg <= '0;
      else          held_reg <= held_next;
   end
`endif

   logic [CMD_WIDTH-1:0] mem_reg [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0]     count_reg, count_next;
   logic                 ready_reg, overflow_reg;
   logic [CMD_WIDTH-1:0] data_reg, head_next;
   logic                 full, pop, push_ok;

   assign full        = (count_reg == CNT_FULL);
   assign pop         = read_fin & ready_reg;
   assign push_ok     = push & (~full | pop);
   assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);

   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop)      count_next = count_reg + CNT_W'(1);
      else if (!push_ok && pop) count_next = count_reg - CNT_W'(1);
   end

   // Head register is refreshed from the post-operation state, bypassing a write into an empty slot.
   always_comb begin
      head_next = '0;
      if (count_next != '0) begin
         if (push_ok && wr_ptr_reg == rd_ptr_next) head_next = push_cmd;
         else                                      head_next = mem_reg[rd_ptr_next];
      end
   end

   always_ff @(posedge clock) begin
      if (push_ok) mem_reg[wr_ptr_reg] <= push_cmd;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         ready_reg    <= 1'b0;
         data_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_reg + PTR_W'(push_ok);
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         ready_reg    <= (count_next != '0);
         data_reg     <= head_next;
         overflow_reg <= overflow_reg | (push & full & ~pop);
      end
   end

   assign ready    = ready_reg;
   assign data     = data_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_ps2_cmd_queue.sv
// tb_ps2_cmd_queue: table-driven PS/2 frame vectors plus hand sequences for latency, full-queue,
// timeout and asynchronous-reset corners.
`timescale 1ns/1ps
module tb_ps2_cmd_queue;
   localparam int CMD_WIDTH      = 3;
   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 200;
   localparam int HALF           = 4;

   logic                 clock = 1'b0;
   logic                 reset_n = 1'b0;
   logic                 ps2_clock = 1'b1;
   logic                 ps2_data = 1'b1;
   logic                 read_fin = 1'b0;
   logic                 ready;
   logic [CMD_WIDTH-1:0] data;
   logic                 overflow;

   int errors = 0;
   int checks = 0;

   ps2_cmd_queue #(
      .CMD_WIDTH(CMD_WIDTH),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .ps2_clock(ps2_clock),
      .ps2_data(ps2_data),
      .read_fin(read_fin),
      .ready(ready),
      .data(data),
      .overflow(overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       send;
      logic [7:0] code;
      logic       bad_par;
      logic       pop;
      logic       exp_ready;
      logic [2:0] exp_data;
      logic       exp_ovf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkv(input logic s, input logic [7:0] c, input logic b, input logic p,
                                input logic r, input logic [2:0] d, input logic o);
      vec_t v;
      v.send = s; v.code = c; v.bad_par = b; v.pop = p;
      v.exp_ready = r; v.exp_data = d; v.exp_ovf = o;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic r, input logic [2:0] d, input logic o);
      check({tag, ".ready"}, 32'(ready), 32'(r));
      check({tag, ".data"}, 32'(data), 32'(d));
      check({tag, ".overflow"}, 32'(overflow), 32'(o));
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(HALF);
      ps2_clock = 1'b0;
      tick(HALF);
      ps2_clock = 1'b1;
      tick(HALF);
   endtask

   // Frame bits LSB first: start, 8 data, odd parity (optionally corrupted), stop.
   task automatic send_frame(input logic [7:0] b, input logic bad, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~(^b)) ^ bad, b, 1'b0};
      for (int i = 0; i < nbits; i++) send_bit(f[i]);
   endtask

   task automatic pop_once();
      read_fin = 1'b1;
      tick(1);
      read_fin = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      // After the latency test the queue is empty and Z is held.
      vecs.push_back(mkv(1, 8'hF0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h1A, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h75, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'hF0, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'h75, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'h75, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(0, 8'h00, 0, 1, 1, 1, 0));
      vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h1A, 0, 0, 1, 5, 0));
      vecs.push_back(mkv(1, 8'h1A, 0, 0, 1, 5, 0));
      vecs.push_back(mkv(1, 8'h1A, 0, 0, 1, 5, 0));
      vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h29, 1, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h22, 0, 0, 1, 6, 0));
      vecs.push_back(mkv(0, 8'h00, 0, 1, 0, 0, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h1A, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h1C, 0, 0, 0, 0, 0));
      // Release up, Z and X so the overflow run starts with nothing held.
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'hF0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h75, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'hF0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h1A, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'hF0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h22, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 0, 0, 0));
      vecs.push_back(mkv(1, 8'h75, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'h72, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'h6B, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'hE0, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'h74, 0, 0, 1, 1, 0));
      vecs.push_back(mkv(1, 8'h1A, 0, 0, 1, 1, 1));

      // Reset state
      tick(3);
      check_out("reset", 0, 0, 0);
      reset_n = 1'b1;
      tick(HALF);

      // Exact latency of a 0x1A frame, then a single pop empties the queue
      send_frame(8'h1A, 0, 10);
      ps2_data = 1'b1;
      tick(HALF);
      ps2_clock = 1'b0;
      tick(3);
      check("lat.ready_early", 32'(ready), 32'd0);
      tick(1);
      check("lat.ready", 32'(ready), 32'd1);
      check("lat.data", 32'(data), 32'd5);
      ps2_clock = 1'b1;
      tick(HALF);
      pop_once();
      check_out("lat.pop", 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].pop) pop_once();
         if (vecs[i].send) send_frame(vecs[i].code, vecs[i].bad_par, 11);
         check_out($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_data, vecs[i].exp_ovf);
      end

      // Queue full with 1,2,3,4: X make lands on the same cycle as a one-cycle read_fin
      send_frame(8'h22, 0, 10);
      ps2_data = 1'b1;
      tick(HALF);
      ps2_clock = 1'b0;
      tick(3);
      read_fin = 1'b1;
      tick(1);
      read_fin = 1'b0;
      check_out("fullpp", 1, 2, 1);
      ps2_clock = 1'b1;
      tick(HALF);
      pop_once();
      check_out("fullpp.pop1", 1, 3, 1);
      pop_once();
      check_out("fullpp.pop2", 1, 4, 1);
      pop_once();
      check_out("fullpp.pop3", 1, 6, 1);
      pop_once();
      check_out("fullpp.pop4", 0, 0, 1);

      // Asynchronous reset clears the sticky overflow between clock edges
      #3;
      reset_n = 1'b0;
      #1;
      check_out("ovf_reset", 0, 0, 0);
      tick(2);
      reset_n = 1'b1;
      tick(HALF);

      // Partial frame abandoned by the timeout, then a clean 0x22
      send_frame(8'h22, 0, 5);
      ps2_data = 1'b1;
      tick(TIMEOUT_CYCLES + 10);
      send_frame(8'h22, 0, 11);
      check_out("timeout", 1, 6, 0);
      pop_once();
      check_out("timeout.pop", 0, 0, 0);

      // Asynchronous reset mid-frame with an entry queued
      send_frame(8'h1A, 0, 11);
      check_out("mid.pre", 1, 5, 0);
      send_frame(8'h22, 0, 4);
      #3;
      reset_n = 1'b0;
      #1;
      check_out("mid.reset", 0, 0, 0);
      ps2_data = 1'b1;
      tick(2);
      reset_n = 1'b1;
      tick(HALF);
      send_frame(8'h1A, 0, 11);
      check_out("mid.after", 1, 5, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
